// File: rtl/spi_master_arb_pkg.sv
// spi_pkg: shared widths, rw encodings and FSM states for spi_master_arb
package spi_pkg;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int FRAME_W = 20;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ = 1'b0;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} spi_mst_state_t;
endpackage

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: one-hot grant picker; round-robin under SPI_ARB_RR_EN, else lowest index wins
module spi_req_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);
`ifdef SPI_ARB_RR_EN
  logic [NUM_REQ-1:0] last, upper, pick;
  assign upper = req & ~((last << 1) - NUM_REQ'(1));
  assign pick = |upper ? upper & (~upper + NUM_REQ'(1)) : req & (~req + NUM_REQ'(1));
  // one-hot record of the last winner; the search resumes just above it and wraps to 0
  always_ff @(posedge clk or negedge reset)
    if (!reset) last <= NUM_REQ'(1) << (NUM_REQ - 1);
    else if (en && |req) last <= pick;
`else
  logic [NUM_REQ-1:0] pick;
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;
  assign pick = req & (~req + NUM_REQ'(1));
`endif
  assign gnt = en ? pick : '0;
endmodule

// File: rtl/spi_master_arb.sv
// spi_master_arb: arbitrated SPI master sending {rw, addr, data} frames; define SPI_ARB_RR_EN for round-robin
module spi_master_arb
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                done_id,
  output logic [DATA_W-1:0]         rdata,
  output logic                      CS,
  output logic                      SCLK,
  output logic                      SDI,
  input  logic                      SDO
);
  localparam int CW = $clog2(2 * CLK_DIV + 1);
  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_req
    $error("NUM_REQ must be in 2..8");
  end
  spi_mst_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [4:0] bitc;
  logic [FRAME_W-1:0] sh, pick_frame;
  logic [DATA_W-1:0] rsh;
  logic sclk, rw_q, tick, arb_en, take, last_bit;
  logic [2:0] id_q, pick_id;
  logic [NUM_REQ-1:0] pick;
  spi_req_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk(clk), .reset(reset), .req(req), .en(arb_en), .gnt(pick)
  );
  assign SCLK = sclk;
  assign SDI = sh[FRAME_W-1];
  // phase timer end, arbitration window (idle or last gap cycle) and the winner's frame
  always_comb begin
    tick = cnt == CW'(state == ST_GAP ? 2 * CLK_DIV - 1 : CLK_DIV - 1);
    arb_en = state == ST_IDLE || (state == ST_GAP && tick);
    take = |pick;
    last_bit = bitc == 5'(FRAME_W - 1);
    pick_id = '0;
    pick_frame = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) begin
        pick_id = 3'(i);
        pick_frame = {req_rw[i], req_addr[ADDR_W*i +: ADDR_W],
                      req_rw[i] == RW_WRITE ? req_wdata[DATA_W*i +: DATA_W] : DATA_W'(0)};
      end
  end
  // next state and bus-level outputs; the gap chains straight into a new grant when one is pending
  always_comb begin
    state_n = state;
    CS = state == ST_IDLE || state == ST_GAP;
    busy = state != ST_IDLE;
    case (state)
      ST_IDLE:  state_n = take ? ST_SETUP : ST_IDLE;
      ST_SETUP: state_n = tick ? ST_SHIFT : ST_SETUP;
      ST_SHIFT: state_n = tick && sclk && last_bit ? ST_HOLD : ST_SHIFT;
      ST_HOLD:  state_n = tick ? ST_GAP : ST_HOLD;
      ST_GAP:   state_n = tick ? (take ? ST_SETUP : ST_IDLE) : ST_GAP;
      default:  state_n = ST_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_n;
  // divider, bit counter, frame/read shift registers and handshake pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      bitc <= '0;
      sh <= '0;
      rsh <= '0;
      sclk <= 1'b1;
      rw_q <= 1'b0;
      id_q <= '0;
      gnt <= '0;
      done <= 1'b0;
      done_id <= '0;
      rdata <= '0;
    end else begin
      cnt <= (state == ST_IDLE || tick) ? '0 : cnt + CW'(1);
      gnt <= pick;
      done <= state == ST_HOLD && tick;
      if (take) begin
        sh <= pick_frame;
        rw_q <= pick_frame[FRAME_W-1];
        id_q <= pick_id;
        bitc <= '0;
      end
      if (state == ST_SETUP && tick) sclk <= 1'b0;
      if (state == ST_SHIFT && tick) begin
        if (!sclk) begin
          sclk <= 1'b1;
          rsh <= {rsh[DATA_W-2:0], SDO};
        end else if (!last_bit) begin
          sclk <= 1'b0;
          bitc <= bitc + 5'd1;
          sh <= sh << 1;
        end
      end
      if (state == ST_HOLD && tick) begin
        done_id <= id_q;
        if (rw_q == RW_READ) rdata <= rsh;
      end
    end
  end
endmodule

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb: randomized scoreboard bench with an SPI slave model for spi_master_arb
module tb_spi_master_arb;
  localparam int N = 2;
  localparam int CD = 2;
  localparam int FRAME_CYC = 42 * CD;
  localparam int SLOT = 44 * CD;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_rw = '0;
  logic [N*11-1:0] req_addr = '0;
  logic [N*8-1:0] req_wdata = '0;
  logic [N-1:0] gnt;
  logic busy, done, CS, SCLK, SDI;
  logic [2:0] done_id;
  logic [7:0] rdata;
  logic SDO = 1'b0;

  spi_master_arb #(.NUM_REQ(N), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .rdata(rdata), .CS(CS), .SCLK(SCLK), .SDI(SDI), .SDO(SDO)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    logic [19:0] frame;
    bit rd;
    int gcyc;
  } exp_t;
  exp_t sb[$];
  exp_t x;
  logic [7:0] sdo_q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_sdi = 1'b0;
  logic [N-1:0] req_prev = '0;
  int rises = 0, hi_cnt = 0, last_gcyc = -1, last_id = N - 1, e;
  logic [19:0] cap = '0;
  logic [7:0] slave_byte = '0;
  bit sdi_bad = 0, aborted = 0, contend = 0, seen_frame = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // arbitration rule: fixed picks the lowest pending index; round-robin starts after the last winner
  function automatic int model_pick(input logic [N-1:0] r, input int last);
    int i;
    for (int k = 1; k <= N; k++) begin
`ifdef SPI_ARB_RR_EN
      i = (last + k) % N;
`else
      i = k - 1;
`endif
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // slave model, bus rule checks, grant checker and scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      last_id = N - 1;
      hi_cnt = 0;
    end else begin
      if (prev_cs && !CS) begin
        if (seen_frame && !aborted) chk("cs_gap_min", 32'(hi_cnt >= 2 * CD), 1);
        aborted = 0;
        seen_frame = 1;
        rises = 0;
        sdi_bad = 0;
        cap = '0;
        slave_byte = sdo_q.size() > 0 ? sdo_q.pop_front() : 8'($urandom);
      end
      hi_cnt = CS ? hi_cnt + 1 : 0;
      if (!CS && SCLK && !prev_sclk) begin
        rises++;
        cap = {cap[18:0], SDI};
      end
      if (!CS && !prev_cs && SCLK && prev_sclk && SDI !== prev_sdi) sdi_bad = 1;
      if (!CS && !SCLK && prev_sclk && rises >= 12 && rises < 20) SDO = slave_byte[7-(rises-12)];
      if (gnt !== '0) begin
        e = model_pick(req_prev, last_id);
        chk("gnt_onehot", 32'(gnt), e < 0 ? 0 : 1 << e);
        if (contend && last_gcyc >= 0) chk("gnt_spacing", cyc - last_gcyc, SLOT);
        last_gcyc = cyc;
        if (e >= 0) begin
          last_id = e;
          sb.push_back('{e, {req_rw[e], req_addr[11*e +: 11], req_rw[e] ? req_wdata[8*e +: 8] : 8'h00},
                         !req_rw[e], cyc});
        end
      end
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          x = sb.pop_front();
          chk("done_id", 32'(done_id), x.id);
          chk("frame_bits", 32'(cap), 32'(x.frame));
          chk("sclk_rises", rises, 20);
          chk("sdi_stable_high", 32'(sdi_bad), 0);
          chk("done_latency", cyc - x.gcyc, FRAME_CYC);
          if (x.rd) chk("rdata", 32'(rdata), 32'(slave_byte));
        end
      end
    end
    prev_cs = CS;
    prev_sclk = SCLK;
    prev_sdi = SDI;
    req_prev = req;
  end

  task automatic wait_gnt(input int i, output bit ok);
    ok = 0;
    for (int k = 0; k < 4 * SLOT && !ok; k++) begin
      @(negedge clk);
      ok = gnt[i];
    end
    chk("gnt_seen", 32'(ok), 1);
  endtask

  task automatic xfer(input int i, input bit rw, input logic [10:0] a, input logic [7:0] d);
    bit ok, got;
    @(posedge clk);
    #1;
    req_rw[i] = rw;
    req_addr[11*i +: 11] = a;
    req_wdata[8*i +: 8] = d;
    req[i] = 1'b1;
    wait_gnt(i, ok);
    @(posedge clk);
    #1;
    req[i] = 1'b0;
    got = 0;
    for (int k = 0; k < 2 * SLOT && !got; k++) begin
      @(negedge clk);
      got = done;
    end
    chk("done_seen", 32'(got), 1);
    repeat (2 * CD - 1) @(negedge clk);
    chk("busy_in_gap", 32'(busy), 1);
    @(negedge clk);
    chk("busy_after_gap", 32'(busy), 0);
  endtask

  initial begin
    bit ok;
    int ng;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(CS), 1);
    chk("rst_sclk", 32'(SCLK), 1);
    chk("rst_sdi", 32'(SDI), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_rdata", 32'(rdata), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    xfer(0, 1'b1, 11'h639, 8'hB3);
    sdo_q.push_back(8'h5A);
    xfer(1, 1'b0, 11'h005, 8'hFF);
    repeat (10) xfer(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), 11'($urandom), 8'($urandom));
    @(posedge clk);
    #1;
    contend = 1;
    last_gcyc = -1;
    req_rw = 2'b10;
    req_addr = {11'h2A5, 11'h15A};
    req_wdata = {8'hC3, 8'h3C};
    req = '1;
    ng = 0;
    for (int k = 0; k < 6 * SLOT && ng < 4; k++) begin
      @(negedge clk);
      if (gnt !== '0) ng++;
    end
    chk("contention_grants", ng, 4);
    @(posedge clk);
    #1;
    req = '0;
    contend = 0;
    for (int k = 0; k < 2 * SLOT && busy; k++) @(negedge clk);
    chk("idle_after_contention", 32'(busy), 0);
    @(posedge clk);
    #1;
    req_rw[0] = 1'b1;
    req_addr[10:0] = 11'h3C7;
    req_wdata[7:0] = 8'h96;
    req[0] = 1'b1;
    wait_gnt(0, ok);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    for (int k = 0; k < SLOT && rises < 10; k++) @(negedge clk);
    chk("reached_bit10", rises, 10);
    #2;
    reset = 1'b0;
    aborted = 1;
    sb.delete();
    #1;
    chk("async_cs", 32'(CS), 1);
    chk("async_sclk", 32'(SCLK), 1);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdata", 32'(rdata), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    xfer(1, 1'b1, 11'h7FF, 8'h81);
    xfer(0, 1'b0, 11'h123, 8'h00);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
